fibonacci_index: RTL

- Inverse of the Fibonacci generator. Accepts a target value with a start pulse.
- Iterates F(k) one term per clock until F(k) >= target, then reports the smallest such index k, whether it was an exact hit, and whether the 32-bit sequence ran out first.
- Sits beside the generator as its consumer/decoder side, for index lookup and result checking.
- Indexing matches the generator: F(1)=F(2)=1, F(3)=2, and reported indices are always >= 2.

---
 rtl/fib_pkg.sv | 20 ++
 rtl/fib_step.sv | 21 ++
 rtl/fibonacci_index.sv | 113 +++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared constants and types for the Fibonacci generator/index blocks.
package fib_pkg;

  localparam int FIB_W_DEFAULT = 32;
  localparam int IDX_W_DEFAULT = 8;

  // Sequence indexing: F(1)=F(2)=1, and reported indices start at 2.
  localparam int FIB_MIN_IDX = 2;

  // Largest index and term that fit in 32 bits.
  localparam int          FIB_MAX_IDX_32 = 47;
  localparam logic [31:0] FIB_MAX_VAL_32 = 32'd2971215073;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } fib_idx_state_t;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: next = prev + cur, with the carry out of the top bit.
// Shared with the generator so both sides advance the sequence identically.
module fib_step #(
  parameter int FIB_W = 32
) (
  input  logic [FIB_W-1:0] prev,
  input  logic [FIB_W-1:0] cur,
  output logic [FIB_W-1:0] next,
  output logic             carry
);

  logic [FIB_W:0] sum;

  // Widened add so the carry shows when the next term no longer fits.
  always_comb begin
    sum   = {1'b0, prev} + {1'b0, cur};
    next  = sum[FIB_W-1:0];
    carry = sum[FIB_W];
  end

endmodule

// File: rtl/fibonacci_index.sv
// Inverse Fibonacci lookup: walks the sequence one term per clock until the
// current term reaches the target, then reports the smallest such index.
//
//   state  | meaning
//   IDLE   | waiting for start; last result held on n/exact/overflow
//   SEARCH | stepping the sequence, comparing cur against target each cycle
//   DONE   | result just written; done pulses; start may chain a new search
module fibonacci_index
  import fib_pkg::*;
#(
  parameter int FIB_W = FIB_W_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FIB_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] n,
  output logic             exact,
  output logic             overflow
);

  fib_idx_state_t state_q, state_d;

  logic [FIB_W-1:0] target_q;
  logic [FIB_W-1:0] prev_q;
  logic [FIB_W-1:0] cur_q;
  logic [IDX_W-1:0] idx_q;

  logic [IDX_W-1:0] n_q;
  logic             exact_q;
  logic             overflow_q;

  logic [FIB_W-1:0] next_term;
  logic             next_carry;
  logic             hit;
  logic             load;

  fib_step #(.FIB_W(FIB_W)) u_step (
    .prev  (prev_q),
    .cur   (cur_q),
    .next  (next_term),
    .carry (next_carry)
  );

  // Compare has priority over overflow: a term that reaches the target wins
  // even when the following sum would no longer fit.
  always_comb begin
    hit  = (cur_q >= target_q);
    load = (state_q != SEARCH) && start;
  end

  // Next-state decode; start is only honoured outside SEARCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SEARCH : IDLE;
      SEARCH:  if (hit || next_carry) state_d = DONE;
      DONE:    state_d = start ? SEARCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sequence walker and result registers; results only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q   <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      exact_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (load) begin
      target_q <= value;
      prev_q   <= FIB_W'(1);
      cur_q    <= FIB_W'(1);
      idx_q    <= IDX_W'(FIB_MIN_IDX);
    end else if (state_q == SEARCH) begin
      if (hit) begin
        n_q        <= idx_q;
        exact_q    <= (cur_q == target_q);
        overflow_q <= 1'b0;
      end else if (next_carry) begin
        n_q        <= idx_q + IDX_W'(1);
        exact_q    <= 1'b0;
        overflow_q <= 1'b1;
      end else begin
        prev_q <= cur_q;
        cur_q  <= next_term;
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  // Status comes straight from registered state, so no input reaches it.
  always_comb begin
    busy     = (state_q == SEARCH);
    done     = (state_q == DONE);
    n        = n_q;
    exact    = exact_q;
    overflow = overflow_q;
  end

endmodule
